// File: rtl/ctrl_decode_pipe.sv
// Registered, handshaked control decoder with multi-cycle mul/div sequencing.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undecodable instructions emit illegal=1 instead of a NOP bundle.
module ctrl_decode_pipe #(
  parameter int OPW           = 5,
  parameter int FNW           = 5,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNTW          = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] alu_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           DMwe,
  output logic           Rwe,
  output logic [1:0]     Rwd,
  output logic [FNW-1:0] ALUop,
  output logic           ALUinB,
  output logic           br_ne,
  output logic           br_lt,
  output logic           jmp,
  output logic           jr_sel,
  output logic           md_start,
  output logic           illegal
);

  typedef struct packed {
    logic           dmwe;
    logic           rwe;
    logic [1:0]     rwd;
    logic [FNW-1:0] aluop;
    logic           aluinb;
    logic           br_ne;
    logic           br_lt;
    logic           jmp;
    logic           jr_sel;
    logic           illegal;
  } ctrl_t;

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [OPW-1:0]  OP_R    = OPW'(0);
  localparam logic [OPW-1:0]  OP_J    = OPW'(1);
  localparam logic [OPW-1:0]  OP_BNE  = OPW'(2);
  localparam logic [OPW-1:0]  OP_JAL  = OPW'(3);
  localparam logic [OPW-1:0]  OP_JR   = OPW'(4);
  localparam logic [OPW-1:0]  OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0]  OP_BLT  = OPW'(6);
  localparam logic [OPW-1:0]  OP_SW   = OPW'(7);
  localparam logic [OPW-1:0]  OP_LW   = OPW'(8);
  localparam logic [FNW-1:0]  FN_MUL  = FNW'(6);
  localparam logic [FNW-1:0]  FN_DIV  = FNW'(7);
  localparam logic [CNTW-1:0] MD_LOAD = CNTW'(MULDIV_CYCLES - 1);
  localparam bit              MD_MULTI = (MULDIV_CYCLES > 1);

  ctrl_t           dec, bun_q, bun_d;
  logic            dec_md;
  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            vld_q, vld_d, mds_q, mds_d;
  logic            accept;

  always_comb begin
    dec    = '0;
    dec_md = 1'b0;
    case (opcode)
      OP_R: begin
        if (alu_in <= FN_DIV) begin
          dec.rwe   = 1'b1;
          dec.aluop = alu_in;
          dec_md    = (alu_in == FN_MUL) || (alu_in == FN_DIV);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_J:    dec.jmp = 1'b1;
      OP_BNE:  begin dec.br_ne = 1'b1; dec.aluop = FNW'(1); end
      OP_JAL:  begin dec.jmp = 1'b1; dec.rwe = 1'b1; dec.rwd = 2'd2; end
      OP_JR:   dec.jr_sel = 1'b1;
      OP_ADDI: begin dec.rwe = 1'b1; dec.aluinb = 1'b1; end
      OP_BLT:  begin dec.br_lt = 1'b1; dec.aluop = FNW'(1); end
      OP_SW:   begin dec.dmwe = 1'b1; dec.aluinb = 1'b1; end
      OP_LW:   begin dec.rwe = 1'b1; dec.rwd = 2'd1; dec.aluinb = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
`else
    // Without the trap, an undecodable instruction is already an all-zero NOP bundle.
    dec.illegal = 1'b0;
`endif
  end

  assign in_ready = (state_q == RUN) && !flush && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    mds_d   = 1'b0;
    bun_d   = bun_q;
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
      vld_d   = 1'b0;
      bun_d   = '0;
    end else if (accept) begin
      bun_d = dec;
      if (dec_md && MD_MULTI) begin
        mds_d   = 1'b1;
        vld_d   = 1'b0;
        state_d = MD_WAIT;
        cnt_d   = MD_LOAD;
      end else begin
        mds_d = dec_md;
        vld_d = 1'b1;
      end
    end else if (state_q == MD_WAIT) begin
      // Counter at 1 means the result lands on the next edge.
      if (cnt_q == CNTW'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
        vld_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      mds_q   <= 1'b0;
      bun_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      mds_q   <= mds_d;
      bun_q   <= bun_d;
    end
  end

  assign out_valid = vld_q;
  assign md_start  = mds_q;
  assign DMwe      = bun_q.dmwe;
  assign Rwe       = bun_q.rwe;
  assign Rwd       = bun_q.rwd;
  assign ALUop     = bun_q.aluop;
  assign ALUinB    = bun_q.aluinb;
  assign br_ne     = bun_q.br_ne;
  assign br_lt     = bun_q.br_lt;
  assign jmp       = bun_q.jmp;
  assign jr_sel    = bun_q.jr_sel;
  assign illegal   = bun_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (MULDIV_CYCLES=4 and =1) share inputs; checked
// against a timeline-based reference model plus directed scenarios.
module tb_ctrl_decode_pipe;

  logic       clock = 1'b0;
  logic       reset_n, flush, in_valid, out_ready;
  logic [4:0] opcode, alu_in;
  logic       in_ready[2], out_valid[2], DMwe[2], Rwe[2], ALUinB[2];
  logic       br_ne[2], br_lt[2], jmp[2], jr_sel[2], md_start[2], illegal[2];
  logic [1:0] Rwd[2];
  logic [4:0] ALUop[2];

  int total = 0;
  int bad   = 0;

  // Bundle layout: {DMwe,Rwe,Rwd,ALUop,ALUinB,br_ne,br_lt,jmp,jr_sel,illegal}
  localparam logic [14:0] B_ADD  = 15'b0_1_00_00000_0_00000;
  localparam logic [14:0] B_LW   = 15'b0_1_01_00000_1_00000;
  localparam logic [14:0] B_SW   = 15'b1_0_00_00000_1_00000;
  localparam logic [14:0] B_ADDI = 15'b0_1_00_00000_1_00000;
  localparam logic [14:0] B_MUL  = 15'b0_1_00_00110_0_00000;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [14:0] B_ILL  = 15'b0_0_00_00000_0_00001;
`else
  localparam logic [14:0] B_ILL  = 15'b0_0_00_00000_0_00000;
`endif

  always #5 clock = ~clock;

  ctrl_decode_pipe #(.OPW(5), .FNW(5), .MULDIV_CYCLES(4), .CNTW(8)) u_md4 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .opcode(opcode), .alu_in(alu_in), .out_valid(out_valid[0]), .out_ready(out_ready),
    .DMwe(DMwe[0]), .Rwe(Rwe[0]), .Rwd(Rwd[0]), .ALUop(ALUop[0]), .ALUinB(ALUinB[0]),
    .br_ne(br_ne[0]), .br_lt(br_lt[0]), .jmp(jmp[0]), .jr_sel(jr_sel[0]),
    .md_start(md_start[0]), .illegal(illegal[0]));

  ctrl_decode_pipe #(.OPW(5), .FNW(5), .MULDIV_CYCLES(1), .CNTW(8)) u_md1 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .opcode(opcode), .alu_in(alu_in), .out_valid(out_valid[1]), .out_ready(out_ready),
    .DMwe(DMwe[1]), .Rwe(Rwe[1]), .Rwd(Rwd[1]), .ALUop(ALUop[1]), .ALUinB(ALUinB[1]),
    .br_ne(br_ne[1]), .br_lt(br_lt[1]), .jmp(jmp[1]), .jr_sel(jr_sel[1]),
    .md_start(md_start[1]), .illegal(illegal[1]));

  // Reference model: which cycle each result is due, not how the RTL counts toward it.
  int          mc[2] = '{4, 1};
  int          cyc = 0;
  bit          m_vld[2], m_pulse[2];
  int          m_due[2];
  logic [14:0] m_bun[2];

  function automatic logic [15:0] ref_dec(input logic [4:0] op, input logic [4:0] fn);
    logic md, dm, rw, ib, bn, bl, j, jr, il;
    logic [1:0] wd;
    logic [4:0] a;
    {md, dm, rw, ib, bn, bl, j, jr, il} = '0;
    wd = 2'd0;
    a  = 5'd0;
    case (op)
      5'd0: if (fn < 5'd8) begin rw = 1; a = fn; md = (fn == 5'd6) || (fn == 5'd7); end
            else il = 1;
      5'd1: j = 1;
      5'd2: begin bn = 1; a = 5'd1; end
      5'd3: begin j = 1; rw = 1; wd = 2'd2; end
      5'd4: jr = 1;
      5'd5: begin rw = 1; ib = 1; end
      5'd6: begin bl = 1; a = 5'd1; end
      5'd7: begin dm = 1; ib = 1; end
      5'd8: begin rw = 1; wd = 2'd1; ib = 1; end
      default: il = 1;
    endcase
`ifndef CTRL_ILLEGAL_TRAP_EN
    il = 0;
`endif
    return {md, dm, rw, wd, a, ib, bn, bl, j, jr, il};
  endfunction

  function automatic logic [14:0] obs(input int i);
    return {DMwe[i], Rwe[i], Rwd[i], ALUop[i], ALUinB[i], br_ne[i], br_lt[i], jmp[i], jr_sel[i], illegal[i]};
  endfunction

  function automatic bit exp_rdy(input int i);
    return !(m_due[i] > cyc) && !flush && (!m_vld[i] || out_ready);
  endfunction

  task automatic set_in(input bit fl, input bit iv, input logic [4:0] op, input logic [4:0] fn, input bit ordy);
    flush = fl; in_valid = iv; opcode = op; alu_in = fn; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    bit          nv[2], np[2];
    int          nd[2];
    logic [14:0] nb[2];
    logic [15:0] d;
    d = ref_dec(opcode, alu_in);
    for (int i = 0; i < 2; i++) begin
      nv[i] = m_vld[i]; np[i] = 0; nd[i] = m_due[i]; nb[i] = m_bun[i];
      if (flush) begin
        nv[i] = 0; nd[i] = -1;
      end else if (in_valid && exp_rdy(i)) begin
        nb[i] = d[14:0];
        if (d[15]) begin
          np[i] = 1;
          if (mc[i] == 1) nv[i] = 1;
          else begin nv[i] = 0; nd[i] = cyc + mc[i]; end
        end else begin
          nv[i] = 1;
        end
      end else if (m_due[i] >= 0 && m_due[i] == cyc + 1) begin
        nv[i] = 1; nd[i] = -1;
      end else if (m_vld[i] && out_ready) begin
        nv[i] = 0;
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = nv[i]; m_pulse[i] = np[i]; m_due[i] = nd[i]; m_bun[i] = nb[i];
    end
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 0;
    set_in(0, 1, 5'd5, 5'd0, 1);
    @(posedge clock); @(posedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({out_valid[i], md_start[i], obs(i)} !== 17'd0) begin
        bad++; $display("FAIL reset_outputs[%0d] got=%b want=0", i, {out_valid[i], md_start[i], obs(i)});
      end
    end
    reset_n = 1;
    set_in(0, 0, 5'd0, 5'd0, 1);
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0; m_pulse[i] = 0; m_due[i] = -1; m_bun[i] = '0;
      total++;
      if (in_ready[i] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d] got=%b want=1", i, in_ready[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops[3]  = '{5'd0, 5'd8, 5'd7};
    logic [14:0] want[3] = '{B_ADD, B_LW, B_SW};
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, ops[k], 5'd0, 1);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (out_valid[i] !== 1'b1 || obs(i) !== want[k]) begin
          bad++; $display("FAIL b2b[%0d] inst%0d got v=%b b=%b want v=1 b=%b", i, k, out_valid[i], obs(i), want[k]);
        end
      end
    end
    set_in(0, 0, 5'd0, 5'd0, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_valid[i] !== 1'b0) begin bad++; $display("FAIL b2b_drain[%0d] got=%b want=0", i, out_valid[i]); end
    end
  endtask

  task automatic test_backpressure();
    set_in(0, 1, 5'd5, 5'd0, 0);
    tick();
    repeat (4) begin
      set_in(0, 1, 5'd8, 5'd0, 0);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (in_ready[i] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready[i]); end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (out_valid[i] !== 1'b1 || obs(i) !== B_ADDI) begin
          bad++; $display("FAIL bp_hold[%0d] got v=%b b=%b want v=1 b=%b", i, out_valid[i], obs(i), B_ADDI);
        end
      end
    end
    set_in(0, 1, 5'd8, 5'd0, 1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (in_ready[i] !== 1'b1) begin bad++; $display("FAIL bp_release[%0d] got=%b want=1", i, in_ready[i]); end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_valid[i] !== 1'b1 || obs(i) !== B_LW) begin
        bad++; $display("FAIL bp_next[%0d] got v=%b b=%b want v=1 b=%b", i, out_valid[i], obs(i), B_LW);
      end
    end
    set_in(0, 0, 5'd0, 5'd0, 1);
    tick();
  endtask

  task automatic test_muldiv();
    set_in(0, 1, 5'd0, 5'd6, 1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (in_ready[i] !== 1'b1) begin bad++; $display("FAIL md_accept[%0d] got=%b want=1", i, in_ready[i]); end
    end
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 0, 5'd0, 5'd0, 1);
      total++;
      if (out_valid[0] !== (k == 4) || md_start[0] !== (k == 1) || in_ready[0] !== (k == 4)) begin
        bad++; $display("FAIL md4 t+%0d got v=%b s=%b r=%b want v=%b s=%b r=%b", k,
                        out_valid[0], md_start[0], in_ready[0], k == 4, k == 1, k == 4);
      end
      if (k == 1 || k == 4) begin
        total++;
        if (ALUop[0] !== 5'd6) begin bad++; $display("FAIL md4_aluop t+%0d got=%0d want=6", k, ALUop[0]); end
      end
      if (k == 4) begin
        total++;
        if (obs(0) !== B_MUL) begin bad++; $display("FAIL md4_bundle got=%b want=%b", obs(0), B_MUL); end
      end
      total++;
      if (out_valid[1] !== (k == 1) || md_start[1] !== (k == 1)) begin
        bad++; $display("FAIL md1 t+%0d got v=%b s=%b want v=%b s=%b", k, out_valid[1], md_start[1], k == 1, k == 1);
      end
      if (k == 1) begin
        total++;
        if (obs(1) !== B_MUL) begin bad++; $display("FAIL md1_bundle got=%b want=%b", obs(1), B_MUL); end
      end
      if (k < 4) tick();
    end
    tick();
  endtask

  task automatic test_flush();
    set_in(0, 1, 5'd0, 5'd7, 1);
    tick();
    set_in(0, 0, 5'd0, 5'd0, 1);
    tick();
    set_in(1, 0, 5'd0, 5'd0, 1);
    total++;
    if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", in_ready[0]); end
    tick();
    set_in(0, 0, 5'd0, 5'd0, 1);
    total++;
    if (out_valid[0] !== 1'b0 || md_start[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL flush_kill got v=%b s=%b r=%b want v=0 s=0 r=1", out_valid[0], md_start[0], in_ready[0]);
    end
    repeat (4) begin
      tick();
      total++;
      if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL flush_no_emit got=%b want=0", out_valid[0]); end
    end
    set_in(1, 1, 5'd5, 5'd0, 1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (in_ready[i] !== 1'b0) begin bad++; $display("FAIL flush_vs_accept[%0d] got=%b want=0", i, in_ready[i]); end
    end
    tick();
    set_in(0, 0, 5'd0, 5'd0, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_valid[i] !== 1'b0) begin bad++; $display("FAIL flush_not_consumed[%0d] got=%b want=0", i, out_valid[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] ops[2] = '{5'd31, 5'd0};
    logic [4:0] fns[2] = '{5'd0, 5'd8};
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1, ops[k], fns[k], 1);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (out_valid[i] !== 1'b1 || obs(i) !== B_ILL) begin
          bad++; $display("FAIL illegal[%0d] case%0d got v=%b b=%b want v=1 b=%b", i, k, out_valid[i], obs(i), B_ILL);
        end
      end
    end
    set_in(0, 0, 5'd0, 5'd0, 1);
    tick();
  endtask

  task automatic test_random();
    logic [4:0] op, fn;
    repeat (600) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
      fn = 5'($urandom_range(0, 9));
      set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, op, fn, $urandom_range(0, 2) != 0);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (in_ready[i] !== exp_rdy(i)) begin
          bad++; $display("FAIL rand_in_ready[%0d] cyc=%0d got=%b want=%b", i, cyc, in_ready[i], exp_rdy(i));
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (out_valid[i] !== m_vld[i] || md_start[i] !== m_pulse[i]) begin
          bad++; $display("FAIL rand_ctl[%0d] cyc=%0d got v=%b s=%b want v=%b s=%b",
                          i, cyc, out_valid[i], md_start[i], m_vld[i], m_pulse[i]);
        end
        if (m_vld[i] || m_pulse[i]) begin
          total++;
          if (obs(i) !== m_bun[i]) begin
            bad++; $display("FAIL rand_bundle[%0d] cyc=%0d got=%b want=%b", i, cyc, obs(i), m_bun[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_muldiv();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Registered, handshaked successor to the single-cycle processor control decoder.
- Decodes a 5-bit opcode and 5-bit ALU function into the datapath control bundle and holds it in a one-stage pipeline register.
- Adds branch, jump and jal/jr controls and an illegal-instruction flag.
- Adds multi-cycle mul/div sequencing: a counter stalls the front end until the mul/div result is ready.

Parameters:
- OPW, 5, opcode field width
- FNW, 5, ALU function field / ALUop width
- MULDIV_CYCLES, 32, cycles from mul/div accept to result valid; legal range 1..255
- CNTW, 8, width of the mul/div cycle counter

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the held/in-flight instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept this cycle
- opcode  in  OPW  instruction opcode
- alu_in  in  FNW  R-type function field
- out_valid  out  1  control bundle valid
- out_ready  in  1  downstream accepts bundle
- DMwe  out  1  data memory write enable
- Rwe  out  1  register file write enable
- Rwd  out  2  writeback select: 0 ALU, 1 memory, 2 PC+1
- ALUop  out  FNW  ALU opcode
- ALUinB  out  1  ALU B select: 0 register, 1 immediate
- br_ne  out  1  bne
- br_lt  out  1  blt
- jmp  out  1  j / jal target jump
- jr_sel  out  1  jump to register
- md_start  out  1  one-cycle pulse starting the mul/div unit
- illegal  out  1  undecodable instruction

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs 0, including out_valid and md_start.
  - in_ready follows its equation; state RUN; counter 0.
- Decode table (all fields not listed are 0; no Z values anywhere):
  - op 00000, alu_in 00000–00101 (add/sub/and/or/sll/sra): Rwe=1, Rwd=0, ALUop=alu_in, ALUinB=0.
  - op 00000, alu_in 00110 (mul) / 00111 (div): Rwe=1, Rwd=0, ALUop=alu_in, multi-cycle.
  - 00101 addi: Rwe=1, ALUinB=1, ALUop=0.
  - 00111 sw: DMwe=1, ALUinB=1.
  - 01000 lw: Rwe=1, Rwd=1, ALUinB=1.
  - 00010 bne: br_ne=1, ALUop=00001.
  - 00110 blt: br_lt=1, ALUop=00001.
  - 00001 j: jmp=1.
  - 00011 jal: jmp=1, Rwe=1, Rwd=2.
  - 00100 jr: jr_sel=1.
  - Anything else, including op 00000 with alu_in >= 01000: illegal instruction.
- Handshake:
  - in_ready = (state==RUN) & ~flush & (~out_valid | out_ready).
  - Accept occurs when in_valid & in_ready. A non-mul/div bundle is registered on accept; out_valid=1 the next cycle.
  - While out_valid & ~out_ready, all outputs hold stable.
  - out_valid clears after out_valid & out_ready unless a new accept occurs the same cycle, giving back-to-back throughput of 1 per cycle.
- FSM states:
  - RUN: accepting instructions.
  - MD_WAIT: mul/div in progress.
- Mul/div sequencing, accept at cycle t:
  - md_start=1 during cycle t+1 only.
  - ALUop is registered at t+1.
  - If MULDIV_CYCLES>1: state goes to MD_WAIT and the counter loads MULDIV_CYCLES-1. The counter decrements each cycle. When it reaches 1, the next cycle sets out_valid=1 and state returns to RUN. out_valid therefore rises at t+MULDIV_CYCLES.
  - If MULDIV_CYCLES==1: MD_WAIT is skipped; out_valid and md_start both assert at t+1.
  - in_ready=0 throughout MD_WAIT.
- Flush:
  - Next edge: out_valid=0, md_start=0, state RUN, counter 0.
  - Flush wins over a simultaneous accept; the presented instruction is not consumed.
- Reset asserted mid-MD_WAIT: immediate return to reset values.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction produces a bundle with illegal=1 and all write/branch/jump enables 0, passed through the normal handshake.
- Undefined: illegal is tied 0 and an undecodable instruction is emitted as a NOP bundle (all controls 0) with out_valid=1.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> all outputs 0. Release -> in_ready=1.
- Back-to-back decode with out_ready=1: R-add (alu_in 00000) then lw (01000) then sw (00111) on consecutive cycles -> out_valid=1 for 3 consecutive cycles with bundles {Rwe=1,Rwd=0,ALUinB=0}, {Rwe=1,Rwd=1,ALUinB=1}, {DMwe=1,Rwe=0}.
- Backpressure: out_ready=0 for 4 cycles after an addi -> bundle held and in_ready=0. out_ready=1 -> next instruction accepted the same cycle.
- Mul/div with MULDIV_CYCLES=4: accept mul (00000/00110) at t -> md_start pulses at t+1; in_ready=0 through t+3; out_valid=1 with ALUop=00110 at t+4. Repeat with MULDIV_CYCLES=1 -> out_valid and md_start both at t+1.
- Flush: assert flush at t+2 during a div -> out_valid stays 0, in_ready=1 at t+3, no bundle emitted. Flush coincident with in_valid=1 -> instruction not accepted.
- Illegal instruction: opcode 11111 -> with CTRL_ILLEGAL_TRAP_EN, illegal=1 and DMwe=Rwe=0. Without the macro, illegal=0, NOP bundle, out_valid=1.
